// File: rtl/branch_resolve.sv
// EX-stage branch/JAL/JALR resolution: target compute, IF/ID/EX flush, redirect to fetch.
// Latency: taken at T -> flush + redirect_valid at T+1; redirect held until redirect_ready.
// Backpressure: busy holds decode while redirecting; optional counters under BRANCH_RESOLVE_PERF_EN.
module branch_resolve #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              is_branch,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic              br_en,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_v,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              redirect_ready,
    output logic              flush,
    output logic              misalign,
    output logic              busy,
    output logic [PERF_W-1:0] perf_br,
    output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_wait
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_WAIT     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              misalign_q, misalign_d;

    logic              taken;
    logic              cond_resolve;
    logic [XLEN-1:0]   target;

    // JALR wins over JAL, JAL over a conditional branch when flags overlap.
    always_comb begin
        taken        = ex_valid & (is_jalr | is_jal | (is_branch & br_en));
        cond_resolve = ex_valid & is_branch & ~is_jal & ~is_jalr;
        if (is_jalr) begin
            target = (rs1_v + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            target = pc + imm;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (taken) begin
                    if (target[1]) begin
                        misalign_d = 1'b1;
                    end else begin
                        target_d = target;
                        state_d  = S_REDIRECT;
                    end
                end
            end
            S_REDIRECT: begin
                state_d = redirect_ready ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            misalign_q <= misalign_d;
        end
    end

    assign redirect_valid = (state_q != S_IDLE);
    assign redirect_pc    = target_q;
    assign flush          = (state_q == S_REDIRECT);
    assign misalign       = misalign_q;
    assign busy           = (state_q != S_IDLE);

`ifdef BRANCH_RESOLVE_PERF_EN
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_taken_q, perf_taken_d;
    logic [PERF_W-1:0] perf_wait_q, perf_wait_d;

    // Only instructions seen in IDLE are resolved; wrong-path ones never count.
    always_comb begin
        perf_br_d    = perf_br_q;
        perf_taken_d = perf_taken_q;
        perf_wait_d  = perf_wait_q;
        if (state_q == S_IDLE && cond_resolve) begin
            perf_br_d = perf_br_q + 1'b1;
            if (br_en) begin
                perf_taken_d = perf_taken_q + 1'b1;
            end
        end
        if (state_q == S_WAIT) begin
            perf_wait_d = perf_wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_br_q    <= '0;
            perf_taken_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            perf_br_q    <= perf_br_d;
            perf_taken_q <= perf_taken_d;
            perf_wait_q  <= perf_wait_d;
        end
    end

    assign perf_br    = perf_br_q;
    assign perf_taken = perf_taken_q;
    assign perf_wait  = perf_wait_q;
`else
    logic unused_cond;
    assign unused_cond = cond_resolve;
    assign perf_br     = '0;
    assign perf_taken  = '0;
    assign perf_wait   = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: driver predicts each cycle's outputs, monitor compares.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, is_branch, is_jal, is_jalr, br_en;
    logic [31:0] pc, imm, rs1_v;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush, misalign, busy;
    logic [31:0] perf_br, perf_taken, perf_wait;

    branch_resolve #(.XLEN(32), .PERF_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .br_en          (br_en),
        .pc             (pc),
        .imm            (imm),
        .rs1_v          (rs1_v),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .misalign       (misalign),
        .busy           (busy),
        .perf_br        (perf_br),
        .perf_taken     (perf_taken),
        .perf_wait      (perf_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          flush;
        bit          misalign;
        bit          busy;
        logic [31:0] pc;
        logic [31:0] n_br;
        logic [31:0] n_taken;
        logic [31:0] n_wait;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: an outstanding redirect plus a flag for its first (flushing) cycle.
    bit          m_pend  = 0;
    bit          m_first = 0;
    logic [31:0] m_pc    = 0;
    logic [31:0] m_br    = 0;
    logic [31:0] m_taken = 0;
    logic [31:0] m_wait  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic step(input bit r, input bit ev, input bit br, input bit jal, input bit jalr,
                        input bit en, input logic [31:0] pcv, input logic [31:0] immv,
                        input logic [31:0] rs1, input bit rdy);
        exp_t        e;
        logic [31:0] tgt;
        bit          was_pend;
        @(negedge clk);
        #1;
        rst_n = r; ex_valid = ev; is_branch = br; is_jal = jal; is_jalr = jalr;
        br_en = en; pc = pcv; imm = immv; rs1_v = rs1; redirect_ready = rdy;
        e.misalign = 0;
        was_pend   = m_pend;
        if (!r) begin
            m_pend = 0; m_first = 0; m_pc = 0;
            m_br = 0; m_taken = 0; m_wait = 0;
        end else if (was_pend) begin
            if (!m_first) m_wait = m_wait + 1;
            if (rdy) m_pend = 0;
            m_first = 0;
        end else if (ev) begin
            if (br && !jal && !jalr) begin
                m_br = m_br + 1;
                if (en) m_taken = m_taken + 1;
            end
            if (jalr || jal || (br && en)) begin
                tgt = jalr ? ((rs1 + immv) & 32'hFFFF_FFFE) : (pcv + immv);
                if (tgt[1]) begin
                    e.misalign = 1;
                end else begin
                    m_pend = 1; m_first = 1; m_pc = tgt;
                end
            end
        end
        e.valid   = m_pend;
        e.flush   = m_pend && m_first;
        e.busy    = m_pend;
        e.pc      = m_pc;
        e.n_br    = m_br;
        e.n_taken = m_taken;
        e.n_wait  = m_wait;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rdy);
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    // Monitor: every record describes the outputs visible after the edge that follows its push.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.valid});
                chk("flush", {31'b0, flush}, {31'b0, e.flush});
                chk("misalign", {31'b0, misalign}, {31'b0, e.misalign});
                chk("busy", {31'b0, busy}, {31'b0, e.busy});
                if (e.valid) chk("redirect_pc", redirect_pc, e.pc);
`ifdef BRANCH_RESOLVE_PERF_EN
                chk("perf_br", perf_br, e.n_br);
                chk("perf_taken", perf_taken, e.n_taken);
                chk("perf_wait", perf_wait, e.n_wait);
`else
                chk("perf_br", perf_br, 32'h0);
                chk("perf_taken", perf_taken, 32'h0);
                chk("perf_wait", perf_wait, 32'h0);
`endif
            end
        end
    end

    initial begin
        logic [31:0] rimm, rpc, rrs1;
        int          kind;
        rst_n = 0; ex_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0; br_en = 0;
        pc = 0; imm = 0; rs1_v = 0; redirect_ready = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 32'h40, 32'h80, 0, 0);
        idle(0);

        // BEQ taken, fetch ready immediately
        step(1, 1, 1, 0, 0, 1, 32'h100, 32'h20, 0, 1);
        idle(1);
        idle(1);
        // BNE not taken
        step(1, 1, 1, 0, 0, 0, 32'h200, 32'h40, 0, 1);
        idle(1);
        // JALR to 0x2002: misaligned
        step(1, 1, 0, 0, 1, 0, 32'h300, 32'h0, 32'h2003, 1);
        idle(1);
        // JAL held off by fetch for three cycles, with taken inputs ignored meanwhile
        step(1, 1, 0, 1, 0, 0, 32'h40, 32'h80, 0, 1);
        step(1, 1, 1, 0, 0, 1, 32'h1000, 32'h10, 0, 0);
        step(1, 1, 0, 1, 0, 0, 32'h2000, 32'h20, 0, 0);
        step(1, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h3000, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // Reset while waiting
        step(1, 1, 0, 1, 0, 0, 32'h500, 32'h100, 0, 0);
        idle(0);
        idle(0);
        step(0, 1, 1, 0, 0, 1, 32'h700, 32'h8, 0, 0);
        idle(1);
        // Wrap-around target
        step(1, 1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20, 0, 1);
        idle(1);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            kind = $urandom_range(0, 9);
            rpc  = $urandom & 32'hFFFF_FFFC;
            rimm = $urandom;
            rimm = (rimm & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
            rrs1 = $urandom;
            step(($urandom_range(0, 150) != 0), ($urandom_range(0, 3) != 0),
                 (kind < 5) || (kind == 9), (kind == 5 || kind == 6 || kind == 9),
                 (kind == 7 || kind == 8), $urandom_range(0, 1) == 1,
                 rpc, rimm, rrs1, $urandom_range(0, 2) != 0);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
